p21_dinostate: RTL and testbench

Game-state and jump-physics controller for the dino game. Synchronises the player jump button, runs the IDLE/RUN/JUMP/DEAD state machine, integrates the dino's vertical height once per video frame, and keeps a 4-digit BCD score. Its `halt` output drives the leg-animation toggler directly. `dino_height` and `score_bcd` feed the pixel renderer, which returns `collision`.

---
 rtl/p21_dino_pkg.sv | 36 +++
 rtl/p21_bcd_counter.sv | 33 +++
 rtl/p21_dinostate.sv | 136 +++++++++++++
 tb/tb_p21_dinostate.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/p21_dino_pkg.sv
// Shared widths, state encoding and BCD helper for the dino game-state controller.
package p21_dino_pkg;

  localparam int unsigned HEIGHT_W = 7;
  localparam int unsigned VEL_W    = 6;
  localparam int unsigned SCORE_W  = 16;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StRun  = 2'd1;
  localparam state_t StJump = 2'd2;
  localparam state_t StDead = 2'd3;

  localparam logic [SCORE_W-1:0] BcdMax = 16'h9999;

  // Four-digit BCD increment; caller guards against wrapping past 9999.
  function automatic logic [SCORE_W-1:0] bcd_inc(input logic [SCORE_W-1:0] val);
    logic [SCORE_W-1:0] res;
    logic               carry;
    res   = val;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (val[4*i +: 4] == 4'd9) begin
          res[4*i +: 4] = 4'd0;
        end else begin
          res[4*i +: 4] = val[4*i +: 4] + 4'd1;
          carry         = 1'b0;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/p21_bcd_counter.sv
// Four-digit saturating BCD score counter with synchronous clear.
module p21_bcd_counter
  import p21_dino_pkg::*;
(
  input  logic               clk,
  input  logic               sys_rst_n,
  input  logic               clr,
  input  logic               inc,
  output logic [SCORE_W-1:0] bcd
);

  logic [SCORE_W-1:0] bcd_q, bcd_d;

  always_comb begin
    bcd_d = bcd_q;
    if (clr) begin
      bcd_d = '0;
    end else if (inc && (bcd_q != BcdMax)) begin
      bcd_d = bcd_inc(bcd_q);
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bcd_q <= '0;
    end else begin
      bcd_q <= bcd_d;
    end
  end

  assign bcd = bcd_q;

endmodule

// File: rtl/p21_dinostate.sv
// Dino game controller: button synchroniser, IDLE/RUN/JUMP/DEAD FSM, per-frame jump
// integration and frame-divided BCD score.
module p21_dinostate
  import p21_dino_pkg::*;
#(
  parameter int unsigned JUMP_V0   = 10,
  parameter int unsigned GRAVITY   = 1,
  parameter int unsigned SCORE_DIV = 6
) (
  input  logic                clk,
  input  logic                sys_rst_n,
  input  logic                frame_tick,
  input  logic                jump_btn,
  input  logic                collision,
  output logic                halt,
  output logic [HEIGHT_W-1:0] dino_height,
  output logic [1:0]          game_state,
  output logic [SCORE_W-1:0]  score_bcd
);

  localparam logic signed [VEL_W-1:0] VelStart = VEL_W'(JUMP_V0);
  localparam logic signed [VEL_W-1:0] VelGrav  = VEL_W'(GRAVITY);
  localparam logic [7:0]              DivLast  = 8'(SCORE_DIV - 1);

  logic sync1_q, sync2_q, delay_q;
  logic press;

  state_t                   state_q, state_d;
  logic                     halt_q;
  logic [HEIGHT_W-1:0]      height_q, height_d;
  logic signed [VEL_W-1:0]  vel_q, vel_d;
  logic [7:0]               div_q, div_d;
  logic                     tick_cnt;
  logic                     score_clr, score_inc;
  logic [HEIGHT_W:0]        sum;
  logic                     land;

  assign press = sync2_q & ~delay_q;

  // Height plus sign-extended velocity in 8-bit two's complement.
  assign sum  = {1'b0, height_q} + {{(HEIGHT_W + 1 - VEL_W){vel_q[VEL_W-1]}}, vel_q};
  assign land = sum[HEIGHT_W] | (sum == '0);

  always_comb begin
    state_d   = state_q;
    height_d  = height_q;
    vel_d     = vel_q;
    div_d     = div_q;
    tick_cnt  = 1'b0;
    score_clr = 1'b0;
    score_inc = 1'b0;
    case (state_q)
      StIdle, StDead: begin
        if (press) begin
          state_d   = StRun;
          height_d  = '0;
          vel_d     = '0;
          div_d     = '0;
          score_clr = 1'b1;
        end
      end
      StRun: begin
        if (collision) begin
          state_d = StDead;
        end else begin
          if (press) begin
            state_d = StJump;
            vel_d   = VelStart;
          end
          tick_cnt = frame_tick;
        end
      end
      StJump: begin
        if (collision) begin
          state_d = StDead;
        end else if (frame_tick) begin
          if (land) begin
            // Landing tick moves only height and state; the divider skips it.
            state_d  = StRun;
            height_d = '0;
            vel_d    = '0;
          end else begin
            height_d = sum[HEIGHT_W-1:0];
            vel_d    = vel_q - VelGrav;
            tick_cnt = 1'b1;
          end
        end
      end
      default: ;
    endcase

    if (tick_cnt) begin
      if (div_q == DivLast) begin
        div_d     = '0;
        score_inc = 1'b1;
      end else begin
        div_d = div_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      delay_q  <= 1'b0;
      state_q  <= StIdle;
      halt_q   <= 1'b1;
      height_q <= '0;
      vel_q    <= '0;
      div_q    <= '0;
    end else begin
      sync1_q  <= jump_btn;
      sync2_q  <= sync1_q;
      delay_q  <= sync2_q;
      state_q  <= state_d;
      halt_q   <= (state_d == StIdle) | (state_d == StDead);
      height_q <= height_d;
      vel_q    <= vel_d;
      div_q    <= div_d;
    end
  end

  p21_bcd_counter u_score (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .clr       (score_clr),
    .inc       (score_inc),
    .bcd       (score_bcd)
  );

  assign halt        = halt_q;
  assign dino_height = height_q;
  assign game_state  = state_q;

endmodule

// File: tb/tb_p21_dinostate.sv
// Scoreboard bench for p21_dinostate plus a standalone check of the BCD saturation.
module tb_p21_dinostate;
  import p21_dino_pkg::*;

  logic        clk        = 1'b0;
  logic        sys_rst_n  = 1'b0;
  logic        frame_tick = 1'b0;
  logic        jump_btn   = 1'b0;
  logic        collision  = 1'b0;
  logic        halt;
  logic [6:0]  dino_height;
  logic [1:0]  game_state;
  logic [15:0] score_bcd;

  logic        b_clr = 1'b0;
  logic        b_inc = 1'b0;
  logic [15:0] b_bcd;

  int checks = 0;
  int errors = 0;

  typedef enum int {SelState, SelHeight, SelScore, SelHalt, SelBcd} sel_e;
  typedef struct {
    string       tag;
    sel_e        sel;
    logic [15:0] exp;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  p21_dinostate dut (
    .clk         (clk),
    .sys_rst_n   (sys_rst_n),
    .frame_tick  (frame_tick),
    .jump_btn    (jump_btn),
    .collision   (collision),
    .halt        (halt),
    .dino_height (dino_height),
    .game_state  (game_state),
    .score_bcd   (score_bcd)
  );

  p21_bcd_counter u_bcd (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .clr       (b_clr),
    .inc       (b_inc),
    .bcd       (b_bcd)
  );

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] observe(input sel_e sel);
    case (sel)
      SelState:  return {14'd0, game_state};
      SelHeight: return {9'd0, dino_height};
      SelScore:  return score_bcd;
      SelHalt:   return {15'd0, halt};
      default:   return b_bcd;
    endcase
  endfunction

  task automatic expect_out(input string tag, input sel_e sel, input logic [15:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq(e.tag, observe(e.sel), e.exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are compared one full cycle later.
  task automatic step(input logic ft, input logic col);
    frame_tick = ft;
    collision  = col;
    @(negedge clk);
    frame_tick = 1'b0;
    collision  = 1'b0;
    drain();
  endtask

  task automatic press_start();
    jump_btn = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  int heights[21] = '{10, 19, 27, 34, 40, 45, 49, 52, 54, 55, 55,
                      54, 52, 49, 45, 40, 34, 27, 19, 10, 0};

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    expect_out("rst_state", SelState, 16'd0);
    expect_out("rst_halt", SelHalt, 16'd1);
    expect_out("rst_height", SelHeight, 16'd0);
    expect_out("rst_score", SelScore, 16'h0000);
    expect_out("rst_bcd", SelBcd, 16'h0000);
    drain();
    sys_rst_n = 1'b1;

    expect_out("idle_col_state", SelState, 16'(StIdle));
    expect_out("idle_col_halt", SelHalt, 16'd1);
    step(1'b1, 1'b1);

    // Button held: exactly one press, RUN after the third edge.
    jump_btn = 1'b1;
    step(1'b0, 1'b0);
    expect_out("press_lat2", SelState, 16'(StIdle));
    step(1'b0, 1'b0);
    expect_out("press_run", SelState, 16'(StRun));
    expect_out("press_halt", SelHalt, 16'd0);
    expect_out("press_score", SelScore, 16'h0000);
    step(1'b0, 1'b0);
    for (int i = 0; i < 97; i++) begin
      expect_out("hold_run", SelState, 16'(StRun));
      step(1'b0, 1'b0);
    end
    jump_btn = 1'b0;
    repeat (3) step(1'b0, 1'b0);

    for (int i = 1; i <= 60; i++) begin
      if (i == 5) expect_out("score_5", SelScore, 16'h0000);
      if (i == 6) expect_out("score_6", SelScore, 16'h0001);
      if (i == 60) expect_out("score_60", SelScore, 16'h0010);
      step(1'b1, 1'b0);
    end

    // Jump; the tick on the start cycle is not integrated.
    press_start();
    expect_out("jump_start_state", SelState, 16'(StJump));
    expect_out("jump_start_height", SelHeight, 16'd0);
    step(1'b1, 1'b0);
    jump_btn = 1'b0;
    for (int t = 0; t < 21; t++) begin
      expect_out($sformatf("jump_h%0d", t + 1), SelHeight, 16'(heights[t]));
      if (t == 0) expect_out("jump_state", SelState, 16'(StJump));
      if (t == 20) expect_out("land_state", SelState, 16'(StRun));
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
    end
    expect_out("jump_score", SelScore, 16'h0013);
    step(1'b0, 1'b0);

    // Collision beats press in RUN.
    press_start();
    expect_out("colpress_state", SelState, 16'(StDead));
    expect_out("colpress_halt", SelHalt, 16'd1);
    step(1'b0, 1'b1);
    jump_btn = 1'b0;
    expect_out("dead_col_state", SelState, 16'(StDead));
    step(1'b0, 1'b1);
    expect_out("dead_score", SelScore, 16'h0013);
    step(1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b0);

    press_start();
    expect_out("restart_state", SelState, 16'(StRun));
    expect_out("restart_score", SelScore, 16'h0000);
    step(1'b0, 1'b0);
    jump_btn = 1'b0;
    repeat (2) step(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
    expect_out("pre_jump_score", SelScore, 16'h0001);
    step(1'b0, 1'b0);

    // Collision at jump tick 5 freezes height and score.
    press_start();
    step(1'b0, 1'b0);
    jump_btn = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    expect_out("tick5_height", SelHeight, 16'd40);
    expect_out("tick5_score", SelScore, 16'h0002);
    step(1'b0, 1'b0);
    expect_out("jcol_state", SelState, 16'(StDead));
    expect_out("jcol_height", SelHeight, 16'd40);
    expect_out("jcol_halt", SelHalt, 16'd1);
    step(1'b1, 1'b1);
    repeat (2) step(1'b1, 1'b0);
    expect_out("frozen_height", SelHeight, 16'd40);
    expect_out("frozen_score", SelScore, 16'h0002);
    step(1'b1, 1'b0);
    press_start();
    expect_out("revive_state", SelState, 16'(StRun));
    expect_out("revive_height", SelHeight, 16'd0);
    expect_out("revive_score", SelScore, 16'h0000);
    step(1'b0, 1'b0);
    jump_btn = 1'b0;
    repeat (2) step(1'b0, 1'b0);

    // Asynchronous reset in the middle of a jump.
    press_start();
    step(1'b0, 1'b0);
    jump_btn = 1'b0;
    repeat (3) step(1'b1, 1'b0);
    expect_out("mid_height", SelHeight, 16'd27);
    step(1'b0, 1'b0);
    #2;
    sys_rst_n = 1'b0;
    #1;
    expect_out("arst_state", SelState, 16'd0);
    expect_out("arst_height", SelHeight, 16'd0);
    expect_out("arst_halt", SelHalt, 16'd1);
    expect_out("arst_score", SelScore, 16'h0000);
    drain();
    @(negedge clk);
    sys_rst_n = 1'b1;
    expect_out("post_rst_state", SelState, 16'(StIdle));
    step(1'b1, 1'b0);

    // BCD counter preload and saturation.
    b_inc = 1'b1;
    repeat (9980) @(negedge clk);
    b_inc = 1'b0;
    expect_out("bcd_9980", SelBcd, 16'h9980);
    step(1'b0, 1'b0);
    b_inc = 1'b1;
    repeat (19) @(negedge clk);
    expect_out("bcd_9999", SelBcd, 16'h9999);
    drain();
    repeat (6) @(negedge clk);
    b_inc = 1'b0;
    expect_out("bcd_sat", SelBcd, 16'h9999);
    drain();
    b_clr = 1'b1;
    @(negedge clk);
    b_clr = 1'b0;
    expect_out("bcd_clr", SelBcd, 16'h0000);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
